// File: rtl/overcooked_pkg.sv
// Shared arena constants, wall encoding and locator state encoding.
package overcooked_pkg;

    localparam int unsigned COORD_W  = 10;
    localparam logic [COORD_W-1:0] NONE = '1;

    localparam int unsigned TILE     = 40;
    localparam int unsigned LEFT_X   = 40;
    localparam int unsigned RIGHT_X  = 600;
    localparam int unsigned TOP_Y    = 100;
    localparam int unsigned BOTTOM_Y = 460;

    typedef enum logic [1:0] {
        LEFT   = 2'b00,
        RIGHT  = 2'b01,
        TOP    = 2'b10,
        BOTTOM = 2'b11
    } wall_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SNAP,
        S_WRITE,
        S_DONE
    } loc_state_e;

    // Top and bottom walls run along X; left and right walls run along Y.
    function automatic logic along_x(input wall_e w);
        return (w == TOP) || (w == BOTTOM);
    endfunction

endpackage

// File: rtl/counter_locator_if.sv
// Player-position inputs and per-player counter results of the locator.
interface counter_locator_if #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned COORD_W     = overcooked_pkg::COORD_W
);

    logic                                  frame_start;
    logic [NUM_PLAYERS-1:0][COORD_W-1:0]   penguinX;
    logic [NUM_PLAYERS-1:0][COORD_W-1:0]   penguinY;
    logic [NUM_PLAYERS-1:0]                touchingWallFlag;
    logic [NUM_PLAYERS-1:0][1:0]           wallIndex;

    logic [NUM_PLAYERS-1:0][COORD_W-1:0]   nearestCounterX;
    logic [NUM_PLAYERS-1:0][COORD_W-1:0]   nearestCounterY;
    logic [NUM_PLAYERS-1:0]                counter_valid;
    logic                                  busy;
    logic                                  done;
    logic                                  overrun;

    modport master (
        output frame_start, penguinX, penguinY, touchingWallFlag, wallIndex,
        input  nearestCounterX, nearestCounterY, counter_valid, busy, done, overrun
    );

    modport slave (
        input  frame_start, penguinX, penguinY, touchingWallFlag, wallIndex,
        output nearestCounterX, nearestCounterY, counter_valid, busy, done, overrun
    );

endinterface

// File: rtl/tile_snap.sv
// Clamps a wall coordinate into the counter run and snaps it to the centre of
// its tile by repeated subtraction, one tile per cycle.
module tile_snap #(
    parameter int unsigned COORD_W = overcooked_pkg::COORD_W,
    parameter int unsigned TILE    = overcooked_pkg::TILE
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               start,
    input  logic [COORD_W-1:0] p,
    input  logic [COORD_W-1:0] origin,
    input  logic [COORD_W-1:0] end_pt,
    output logic [COORD_W-1:0] result,
    output logic               ready
);

    // One spare bit so base+TILE/2 and end-1 never wrap.
    localparam int unsigned AW = COORD_W + 1;

    logic [AW-1:0] p_w;
    logic [AW-1:0] org_w;
    logic [AW-1:0] end_w;
    logic [AW-1:0] clamp_c;
    logic [AW-1:0] r0_c;
    logic [AW-1:0] r_q;
    logic [AW-1:0] base_q;
    logic [AW-1:0] r_dec_c;
    logic [AW-1:0] base_inc_c;

    // Clamp into [origin, end-1] and compute the next subtract step.
    always_comb begin
        p_w        = AW'(p);
        org_w      = AW'(origin);
        end_w      = AW'(end_pt);
        clamp_c    = p_w;
        if (p_w < org_w) begin
            clamp_c = org_w;
        end else if (p_w >= end_w) begin
            clamp_c = end_w - AW'(1);
        end
        r0_c       = clamp_c - org_w;
        r_dec_c    = r_q - AW'(TILE);
        base_inc_c = base_q + AW'(TILE);
    end

    // ready mirrors (r < TILE); result is precomputed so both are registered.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_q    <= '0;
            base_q <= '0;
            ready  <= 1'b1;
            result <= '0;
        end else if (start) begin
            r_q    <= r0_c;
            base_q <= org_w;
            ready  <= (r0_c < AW'(TILE));
            result <= COORD_W'(org_w + AW'(TILE / 2));
        end else if (!ready) begin
            r_q    <= r_dec_c;
            base_q <= base_inc_c;
            ready  <= (r_dec_c < AW'(TILE));
            result <= COORD_W'(base_inc_c + AW'(TILE / 2));
        end
    end

endmodule

// File: rtl/counter_locator.sv
// Once per frame, resolves the facing counter tile centre for every player
// through one shared tile_snap and publishes registered per-player results.
module counter_locator #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned COORD_W     = overcooked_pkg::COORD_W,
    parameter int unsigned TILE        = overcooked_pkg::TILE,
    parameter int unsigned LEFT_X      = overcooked_pkg::LEFT_X,
    parameter int unsigned RIGHT_X     = overcooked_pkg::RIGHT_X,
    parameter int unsigned TOP_Y       = overcooked_pkg::TOP_Y,
    parameter int unsigned BOTTOM_Y    = overcooked_pkg::BOTTOM_Y
) (
    input  logic             Clk,
    input  logic             Reset,
    counter_locator_if.slave bus
);

    import overcooked_pkg::*;

    localparam int unsigned IDX_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam logic [COORD_W-1:0] NO_COUNTER = '1;

    loc_state_e                            state;
    logic [IDX_W-1:0]                      idx;

    logic [NUM_PLAYERS-1:0][COORD_W-1:0]   px_q;
    logic [NUM_PLAYERS-1:0][COORD_W-1:0]   py_q;
    logic [NUM_PLAYERS-1:0]                touch_q;
    logic [NUM_PLAYERS-1:0][1:0]           wall_q;

    logic [NUM_PLAYERS-1:0][COORD_W-1:0]   res_x;
    logic [NUM_PLAYERS-1:0][COORD_W-1:0]   res_y;
    logic [NUM_PLAYERS-1:0]                valid_q;
    logic                                  busy_q;
    logic                                  done_q;
    logic                                  overrun_q;

    wall_e                                 cur_wall_c;
    logic                                  along_x_c;
    logic                                  snap_start_c;
    logic [COORD_W-1:0]                    snap_p_c;
    logic [COORD_W-1:0]                    snap_org_c;
    logic [COORD_W-1:0]                    snap_end_c;
    logic [COORD_W-1:0]                    fixed_c;
    logic [COORD_W-1:0]                    wr_x_c;
    logic [COORD_W-1:0]                    wr_y_c;
    logic [COORD_W-1:0]                    snap_result;
    logic                                  snap_ready;

    // Per-player selection of the along-wall coordinate, its run and the fixed axis.
    always_comb begin
        cur_wall_c   = wall_e'(wall_q[idx]);
        along_x_c    = along_x(cur_wall_c);
        snap_p_c     = along_x_c ? px_q[idx] : py_q[idx];
        snap_org_c   = along_x_c ? COORD_W'(LEFT_X)  : COORD_W'(TOP_Y);
        snap_end_c   = along_x_c ? COORD_W'(RIGHT_X) : COORD_W'(BOTTOM_Y);
        snap_start_c = (state == S_LOAD) && touch_q[idx];

        fixed_c = COORD_W'(LEFT_X);
        case (cur_wall_c)
            LEFT:    fixed_c = COORD_W'(LEFT_X);
            RIGHT:   fixed_c = COORD_W'(RIGHT_X);
            TOP:     fixed_c = COORD_W'(TOP_Y);
            BOTTOM:  fixed_c = COORD_W'(BOTTOM_Y);
            default: fixed_c = COORD_W'(LEFT_X);
        endcase

        wr_x_c = NO_COUNTER;
        wr_y_c = NO_COUNTER;
        if (touch_q[idx]) begin
            if (along_x_c) begin
                wr_x_c = snap_result;
                wr_y_c = fixed_c;
            end else begin
                wr_x_c = fixed_c;
                wr_y_c = snap_result;
            end
        end
    end

    tile_snap #(
        .COORD_W (COORD_W),
        .TILE    (TILE)
    ) u_snap (
        .Clk     (Clk),
        .Reset   (Reset),
        .start   (snap_start_c),
        .p       (snap_p_c),
        .origin  (snap_org_c),
        .end_pt  (snap_end_c),
        .result  (snap_result),
        .ready   (snap_ready)
    );

    // Pass sequencer: snapshot, per-player load/snap/write, then done pulse.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            px_q      <= '0;
            py_q      <= '0;
            touch_q   <= '0;
            wall_q    <= '0;
            res_x     <= {NUM_PLAYERS{NO_COUNTER}};
            res_y     <= {NUM_PLAYERS{NO_COUNTER}};
            valid_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            overrun_q <= bus.frame_start && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (bus.frame_start) begin
                        px_q    <= bus.penguinX;
                        py_q    <= bus.penguinY;
                        touch_q <= bus.touchingWallFlag;
                        wall_q  <= bus.wallIndex;
                        valid_q <= '0;
                        idx     <= '0;
                        busy_q  <= 1'b1;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state <= touch_q[idx] ? S_SNAP : S_WRITE;
                end
                S_SNAP: begin
                    if (snap_ready) begin
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    res_x[idx]   <= wr_x_c;
                    res_y[idx]   <= wr_y_c;
                    valid_q[idx] <= 1'b1;
                    if (idx == IDX_W'(NUM_PLAYERS - 1)) begin
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    idx    <= '0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.nearestCounterX = res_x;
    assign bus.nearestCounterY = res_y;
    assign bus.counter_valid   = valid_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.overrun         = overrun_q;

endmodule

// File: tb/tb_counter_locator.sv
// Scoreboard bench for counter_locator with default arena parameters.
module tb_counter_locator;

    import overcooked_pkg::*;

    typedef struct {
        int          x;
        int          y;
        bit          t;
        logic [1:0]  w;
        int          ex;
        int          ey;
        int          vlat;
    } pl_t;

    typedef struct {
        pl_t pl [2];
        int  dlat;
    } pass_t;

    logic Clk = 1'b0;
    logic Reset;

    counter_locator_if #(.NUM_PLAYERS(2), .COORD_W(10)) bus ();

    counter_locator #(.NUM_PLAYERS(2)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int cycle_count = 0;
    int checks      = 0;
    int errors      = 0;
    int t_start     = 0;
    int done_cycles = 0;
    int pass_no     = 0;
    int rise_lat [2];
    logic [1:0] prev_valid = 2'b00;
    pass_t exp_q [$];

    always @(posedge Clk) cycle_count++;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    function automatic pl_t mk(input int x, input int y, input bit t, input wall_e w,
                               input int ex, input int ey, input int vlat);
        pl_t r;
        r.x = x; r.y = y; r.t = t; r.w = w;
        r.ex = ex; r.ey = ey; r.vlat = vlat;
        return r;
    endfunction

    // Monitor: records valid rise times and checks a whole pass on each done.
    always @(negedge Clk) begin
        if (Reset) begin
            rise_lat[0] = 0;
            rise_lat[1] = 0;
            prev_valid  = 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (bus.counter_valid[i] && !prev_valid[i]) rise_lat[i] = cycle_count - t_start;
            end
            prev_valid = bus.counter_valid;
            if (bus.done) begin
                done_cycles++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done at cycle %0d, required no pass pending", cycle_count);
                end else begin
                    pass_t e;
                    e = exp_q.pop_front();
                    pass_no++;
                    for (int i = 0; i < 2; i++) begin
                        chk($sformatf("pass%0d_p%0d_x", pass_no, i), int'(bus.nearestCounterX[i]), e.pl[i].ex);
                        chk($sformatf("pass%0d_p%0d_y", pass_no, i), int'(bus.nearestCounterY[i]), e.pl[i].ey);
                        chk($sformatf("pass%0d_p%0d_valid_lat", pass_no, i), rise_lat[i], e.pl[i].vlat);
                        rise_lat[i] = 0;
                    end
                    chk($sformatf("pass%0d_valid", pass_no), int'(bus.counter_valid), 3);
                    chk($sformatf("pass%0d_done_lat", pass_no), cycle_count - t_start, e.dlat);
                end
            end
        end
    end

    task automatic apply_inputs(input pass_t v);
        for (int i = 0; i < 2; i++) begin
            bus.penguinX[i]         = 10'(v.pl[i].x);
            bus.penguinY[i]         = 10'(v.pl[i].y);
            bus.touchingWallFlag[i] = v.pl[i].t;
            bus.wallIndex[i]        = v.pl[i].w;
        end
    endtask

    task automatic start_pass(input pass_t v, input bit expect_done);
        @(negedge Clk);
        apply_inputs(v);
        bus.frame_start = 1'b1;
        t_start = cycle_count;
        if (expect_done) exp_q.push_back(v);
        @(negedge Clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge Clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic chk_reset_values(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_x%0d", tag, i), int'(bus.nearestCounterX[i]), int'(NONE));
            chk($sformatf("%s_y%0d", tag, i), int'(bus.nearestCounterY[i]), int'(NONE));
        end
        chk({tag, "_valid"},   int'(bus.counter_valid), 0);
        chk({tag, "_busy"},    int'(bus.busy), 0);
        chk({tag, "_done"},    int'(bus.done), 0);
        chk({tag, "_overrun"}, int'(bus.overrun), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog timeout");
    end

    initial begin
        pass_t t1, t2, t3, t4, t6, junk;
        int n;

        t1.pl[0] = mk(130, 0,   1, TOP,    140,  100,  6);
        t1.pl[1] = mk(0,   0,   0, LEFT,   1023, 1023, 8);
        t1.dlat  = 8;
        t2.pl[0] = mk(130, 0,   1, TOP,    140,  100,  6);
        t2.pl[1] = mk(20,  0,   1, BOTTOM, 60,   460,  9);
        t2.dlat  = 9;
        t3.pl[0] = mk(0,   475, 1, RIGHT,  600,  440,  12);
        t3.pl[1] = mk(0,   100, 1, LEFT,   40,   120,  15);
        t3.dlat  = 15;
        t4.pl[0] = mk(130, 0,   0, TOP,    1023, 1023, 3);
        t4.pl[1] = mk(0,   250, 1, LEFT,   40,   240,  9);
        t4.dlat  = 9;
        t6.pl[0] = mk(599, 0,   1, TOP,    580,  100,  17);
        t6.pl[1] = mk(599, 0,   1, TOP,    580,  100,  33);
        t6.dlat  = 33;
        junk.pl[0] = mk(300, 300, 0, BOTTOM, 0, 0, 0);
        junk.pl[1] = mk(300, 300, 0, BOTTOM, 0, 0, 0);
        junk.dlat  = 0;

        Reset = 1'b1;
        bus.frame_start = 1'b0;
        apply_inputs(junk);
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk_reset_values("reset");

        start_pass(t1, 1'b1);
        chk("busy_after_start", int'(bus.busy), 1);
        drain();
        start_pass(t2, 1'b1);
        drain();
        start_pass(t3, 1'b1);
        drain();
        start_pass(t4, 1'b1);
        drain();

        // frame_start while busy, with inputs changed mid-pass
        start_pass(t3, 1'b1);
        repeat (2) @(negedge Clk);
        apply_inputs(junk);
        bus.frame_start = 1'b1;
        @(negedge Clk);
        chk("overrun_pulse", int'(bus.overrun), 1);
        bus.frame_start = 1'b0;
        @(negedge Clk);
        chk("overrun_clear", int'(bus.overrun), 0);
        drain();

        // frame_start during the DONE cycle
        start_pass(t1, 1'b1);
        n = 0;
        while (!bus.done && n < 100) begin
            @(negedge Clk);
            n++;
        end
        chk("done_seen", int'(bus.done), 1);
        bus.frame_start = 1'b1;
        @(negedge Clk);
        bus.frame_start = 1'b0;
        chk("done_cycle_overrun", int'(bus.overrun), 1);
        chk("done_cycle_busy", int'(bus.busy), 0);
        @(negedge Clk);
        chk("done_cycle_no_restart", int'(bus.busy), 0);
        drain();

        // asynchronous reset in the middle of the first player's snap
        start_pass(t6, 1'b0);
        repeat (3) @(negedge Clk);
        chk("busy_before_reset", int'(bus.busy), 1);
        #2 Reset = 1'b1;
        #1 chk_reset_values("midpass_reset");
        @(negedge Clk);
        Reset = 1'b0;

        start_pass(t6, 1'b1);
        drain();

        chk("done_pulse_cycles", done_cycles, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
